div_iterative: RTL and testbench

- Multi-cycle RISC-V M-extension divider feeding the execute stage through the div_in/div_out handshake.
- Execute drives operands, op and enable, then stalls until ready is seen; the result is muxed into the writeback data.
- Radix-2 restoring algorithm, one quotient bit per cycle, with fast paths for divide-by-zero and signed overflow.

---
 rtl/div_iterative.sv | 169 ++++++++++++++++
 tb/tb_div_iterative.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iterative.sv
`default_nettype none
// ============================================================================
// div_iterative : radix-2 restoring divider for RISC-V M-extension div/rem ops
// Revision      : 1.0
// ============================================================================
module div_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] LSB_ONE   = XLEN'(1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;  // {is_rem, is_signed}
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed;
  logic            in_rem;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] quot_next;
  logic [XLEN-1:0] rem_low;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  // Anything other than a clean one-hot op code falls back to divu.
  always_comb begin
    in_signed = 1'b0;
    in_rem    = 1'b0;
    case (op)
      4'b0001: begin in_signed = 1'b1; in_rem = 1'b0; end
      4'b0100: begin in_signed = 1'b1; in_rem = 1'b1; end
      4'b1000: begin in_signed = 1'b0; in_rem = 1'b1; end
      default: begin in_signed = 1'b0; in_rem = 1'b0; end
    endcase
    abs1 = (in_signed && rdata1[XLEN-1]) ? -rdata1 : rdata1;
    abs2 = (in_signed && rdata2[XLEN-1]) ? -rdata2 : rdata2;
  end

  // The stored remainder is always below the divisor, so only the shifted
  // trial value needs the extra bit.
  always_comb begin
    shifted   = {rem_q, dividend_q[XLEN-1]};
    diff      = shifted - {1'b0, divisor_q};
    q_bit     = ~diff[XLEN];
    quot_next = (quot_q << 1) | (q_bit ? LSB_ONE : '0);
    rem_low   = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_fix  = (op_q == 2'b01 && negq_q) ? -quot_next : quot_next;
    rem_fix   = (op_q == 2'b11 && negr_q) ? -rem_low : rem_low;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            op_d       = {in_rem, in_signed};
            dividend_d = abs1;
            divisor_d  = abs2;
            negq_d     = in_signed & (rdata1[XLEN-1] ^ rdata2[XLEN-1]);
            negr_d     = in_signed & rdata1[XLEN-1];
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = '0;
            if (rdata2 == '0) begin
              state_d  = S_DONE;
              result_d = in_rem ? rdata1 : '1;
            end else if (in_signed && rdata1 == MIN_NEG && rdata2 == '1) begin
              state_d  = S_DONE;
              result_d = in_rem ? '0 : rdata1;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          dividend_d = dividend_q << 1;
          rem_d      = rem_low;
          quot_d     = quot_next;
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q == LAST_ITER) begin
            state_d  = S_DONE;
            result_d = op_q[1] ? rem_fix : quot_fix;
          end
        end
        // Enable here is the completing instruction still in execute, not a new request.
        S_DONE: begin
          if (enable) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_iterative.sv
`default_nettype none
// ============================================================================
// tb_div_iterative : directed self-checking bench for div_iterative
// Revision         : 1.0
// ============================================================================
module tb_div_iterative;

  localparam int XLEN = 32;

  localparam logic [3:0] DIV  = 4'b0001;
  localparam logic [3:0] DIVU = 4'b0010;
  localparam logic [3:0] REM  = 4'b0100;
  localparam logic [3:0] REMU = 4'b1000;

  logic            clock  = 1'b0;
  logic            reset  = 1'b1;
  logic            enable = 1'b0;
  logic            clear  = 1'b0;
  logic [3:0]      op     = 4'b0000;
  logic [XLEN-1:0] rdata1 = '0;
  logic [XLEN-1:0] rdata2 = '0;
  logic [XLEN-1:0] result;
  logic            ready;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  div_iterative #(.XLEN(XLEN)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .op     (op),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .result (result),
    .ready  (ready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural answer from the RISC-V rules, plus whether it takes the 1-cycle path.
  function automatic logic [31:0] golden(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, output bit fast);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int k;
    sa = a;
    sb = b;
    fast = 1'b0;
    case (o)
      DIV:     k = 0;
      REM:     k = 2;
      REMU:    k = 3;
      default: k = 1;
    endcase
    if (b == 32'd0) begin
      fast = 1'b1;
      return (k >= 2) ? a : 32'hFFFF_FFFF;
    end
    if ((k == 0 || k == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      fast = 1'b1;
      return (k == 0) ? a : 32'd0;
    end
    case (k)
      0:       return sa / sb;
      1:       return a / b;
      2:       return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Reference timeline: accepted request -> answer visible after its latency.
  int          m_mode   = 0;
  int          m_left   = 0;
  logic        m_ready  = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;
  bit          m_fast;

  always @(posedge clock) begin
    if (reset) begin
      m_mode   = 0;
      m_ready  = 1'b0;
      m_result = '0;
    end else if (clear) begin
      m_mode  = 0;
      m_ready = 1'b0;
    end else begin
      case (m_mode)
        0: if (enable) begin
          m_pend = golden(op, rdata1, rdata2, m_fast);
          m_left = m_fast ? 0 : XLEN;
          if (m_fast) begin
            m_mode = 2; m_ready = 1'b1; m_result = m_pend;
          end else begin
            m_mode = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2; m_ready = 1'b1; m_result = m_pend;
          end
        end
        default: if (enable) begin
          m_mode  = 0;
          m_ready = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_ready", {31'd0, ready}, {31'd0, m_ready});
      check("model_result", result, m_result);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op     = o;
    rdata1 = a;
    rdata2 = b;
    enable = 1'b1;
  endtask

  // Called in the cycle numbered start_cyc; returns at the negedge of the ready cycle.
  task automatic wait_ready(input string name, input logic [31:0] exp, input int lat,
                            input int start_cyc);
    int  cyc;
    bit  done;
    cyc  = start_cyc;
    done = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        done = 1'b1;
      end else if (cyc >= 200) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_ready required=ready_by_cycle_%0d", name, lat);
        done = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        cyc++;
      end
    end
    check({name, "_lat"}, cyc, lat);
    check({name, "_res"}, result, exp);
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    start(o, a, b);
    wait_ready(name, exp, lat, 0);
    tick(1);
    enable = 1'b0;
    @(negedge clock);
    check({name, "_idle"}, {31'd0, ready}, 32'd0);
    tick(1);
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV] = '{
    '{DIV,     32'd100,        32'd7,          32'd14,         33},
    '{REM,     32'd100,        32'd7,          32'd2,          33},
    '{DIV,     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
    '{REM,     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
    '{DIVU,    32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33},
    '{REMU,    32'hFFFF_FFF9,  32'd2,          32'd1,          33},
    '{DIV,     32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1},
    '{DIVU,    32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1},
    '{REM,     32'h0000_1234,  32'd0,          32'h0000_1234,  1},
    '{REMU,    32'h0000_1234,  32'd0,          32'h0000_1234,  1},
    '{DIV,     32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
    '{REM,     32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1},
    '{DIVU,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33},
    '{REMU,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33},
    '{DIV,     32'h8000_0000,  32'd2,          32'hC000_0000,  33},
    '{REM,     32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33},
    '{DIV,     32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33},
    '{REM,     32'd7,          32'hFFFF_FFFE,  32'd1,          33},
    '{4'b0011, 32'd100,        32'd7,          32'd14,         33},
    '{4'b0000, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33},
    '{DIVU,    32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33},
    '{REMU,    32'hFFFF_FFFF,  32'd10,         32'd5,          33}
  };

  initial begin
    tick(1);
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_result", result, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < NV; i++) begin
      run($sformatf("v%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Back-to-back: second request lands the cycle after the first ready.
    start(DIVU, 32'd10, 32'd3);
    wait_ready("b2b_first", 32'd3, 33, 0);
    tick(1);
    start(DIVU, 32'd9, 32'd4);
    wait_ready("b2b_second", 32'd2, 33, 0);
    tick(1);
    enable = 1'b0;
    tick(2);

    // Abort in the middle of an iteration, then restart immediately.
    start(DIV, 32'd1000, 32'd10);
    tick(15);
    enable = 1'b0;
    clear  = 1'b1;
    tick(1);
    clear = 1'b0;
    start(DIV, 32'hFFFF_FC18, 32'd10);
    wait_ready("clr_restart", 32'hFFFF_FF9C, 33, 0);
    tick(1);
    enable = 1'b0;
    tick(2);

    // Clear must also beat a request arriving in idle.
    clear = 1'b1;
    start(DIV, 32'd5, 32'd0);
    tick(1);
    clear  = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    check("clr_idle_ready", {31'd0, ready}, 32'd0);
    tick(3);

    // External stall covering the completion cycle and three more.
    start(DIVU, 32'd1000, 32'd7);
    tick(1);
    enable = 1'b0;
    wait_ready("stall", 32'd142, 33, 1);
    tick(3);
    @(negedge clock);
    check("stall_hold_ready", {31'd0, ready}, 32'd1);
    check("stall_hold_result", result, 32'd142);
    tick(1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    @(negedge clock);
    check("stall_release", {31'd0, ready}, 32'd0);
    check("stall_result_kept", result, 32'd142);
    tick(2);

    // Reset partway through an operation, then an immediate new request.
    start(DIV, 32'd100, 32'd7);
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    start(REM, 32'd100, 32'd7);
    @(negedge clock);
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clock);
    #1;
    wait_ready("rst_mid_new", 32'd2, 33, 1);
    tick(1);
    enable = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
